dispatch_rr_multi: RTL and testbench
====================================

// Module: dispatch_rr_multi
// PURPOSE
//  Parametrised dispatch stage between rename and N_CH reservation stations (ALU/BR/LSU/...).
//  Renamed packets are steered by channel index into per-channel FIFOs of depth DEPTH.
//  One packet per cycle is granted by round-robin to its RS and to the single ROB allocation port.
//  Source readiness is resolved at grant from the PRF query plus N_CDB wakeup-bypass ports.
// PARAMETERS
//  N_CH       3    number of RS channels (>=2)
//  DEPTH      2    entries per channel FIFO (power of 2, >=2)
//  PREG_W     7    physical register tag width
//  PAYLOAD_W  96   opaque packet bits (opcode, pc, imm, func3/7, rob tag) carried unmodified
//  N_CDB      3    number of wakeup broadcast ports
// PORTS
//  clk          in   1                  clock, rising edge
//  reset        in   1                  asynchronous, active-high; clears all state
//  flush        in   1                  mispredict: discard every buffered packet
//  in_valid     in   1                  rename packet valid
//  in_ready     out  1                  packet accepted when in_valid && in_ready
//  in_ch        in   $clog2(N_CH)       destination channel
//  in_ps1       in   PREG_W             source 1 physical register (0 = none)
//  in_ps2       in   PREG_W             source 2 physical register (0 = none)
//  in_pd        in   PREG_W             destination physical register (0 = none)
//  in_payload   in   PAYLOAD_W          opaque payload
//  nr_valid     out  1                  mark nr_reg busy in PRF this cycle
//  nr_reg       out  PREG_W             register to mark busy (= in_pd)
//  query_ps1    out  PREG_W             PRF readiness query, granted head source 1
//  query_ps2    out  PREG_W             PRF readiness query, granted head source 2
//  query_rdy1   in   1                  PRF ready bit for query_ps1 (same cycle)
//  query_rdy2   in   1                  PRF ready bit for query_ps2 (same cycle)
//  cdb_valid    in   N_CDB              wakeup broadcast valid per port
//  cdb_tag      in   N_CDB*PREG_W       wakeup tags, port k at [k*PREG_W +: PREG_W]
//  rob_full     in   1                  ROB cannot allocate this cycle
//  rob_we       out  1                  ROB allocation strobe (= |rs_we)
//  rs_space     in   N_CH               per-RS free-slot indication
//  rs_we        out  N_CH               one-hot write strobe to granted RS
//  out_ps1/out_ps2/out_pd  out  PREG_W  granted packet register fields
//  out_payload  out  PAYLOAD_W          granted packet payload
//  out_pr1_ready/out_pr2_ready  out  1  resolved source readiness
// BEHAVIOUR
//  Reset: FIFOs empty, rr_ptr=0; while reset high in_ready=0 and rs_we, rob_we and nr_valid are 0.
//  out_* fields are 0 when no grant.
//  FIFO: in_ready = !reset && !flush && count[in_ch] < DEPTH, from registered count only.
//   - No credit for a same-cycle dequeue.
//   - in_ch >= N_CH: in_ready=1, packet dropped, nr_valid=0.
//  Enqueue: nr_valid = in_valid && in_ready && in_pd!=0 && in_ch<N_CH, asserted in the accept cycle.
//  Latency: minimum 1 cycle from accept to grant; no input-to-output bypass.
//  Enqueue and dequeue on the same channel in one cycle is legal; count is unchanged.
//   - Pointers wrap mod DEPTH.
//  Eligibility: elig[c] = count[c]!=0 && rs_space[c] && !rob_full && !flush.
//  Grant: first elig channel at or after rr_ptr, cyclic; at most one per cycle.
//   - On grant, rr_ptr <= grant+1 mod N_CH; otherwise rr_ptr holds.
//  Readiness at grant: prX_ready = (psX==0) || query_rdyX || any k (cdb_valid[k] && cdb_tag[k]==psX).
//   - This covers wakeups broadcast while the packet sits in a FIFO and in the grant cycle itself.
//  Flush: combinationally forces in_ready=0, rs_we=0, rob_we=0, nr_valid=0.
//   - At the next edge every count/pointer clears; rr_ptr is kept.
//  Reset asserted mid-operation clears state asynchronously; no partial grant completes.
//  rob_full or a channel's rs_space low stalls only the affected grants; no packet is lost or duplicated.
// TESTING
//  1. Reset, then enqueue ch0,ch1,ch2 on 3 cycles (rs_space=111) -> rs_we 001,010,100 on cycles 2,3,4; rob_we each.
//  2. Fill ch1 with 2 packets, rs_space[1]=0 -> in_ready=0 for in_ch=1, still 1 for in_ch=0; release -> FIFO order kept.
//  3. Head ps1=5, query_rdy1=0, cdb_valid=010, tag1=5 in grant cycle -> out_pr1_ready=1; ps2=0 -> out_pr2_ready=1.
//  4. All channels non-empty, rr_ptr=2 -> grant order 2,0,1,2; rob_full held 2 cycles -> no rs_we, order resumes unchanged.
//  5. flush with 4 packets buffered -> no rs_we that cycle, all counts 0 next cycle, in_ready=1 after.
//  6. Accept in_pd=0 -> nr_valid=0; in_pd=9 -> nr_valid=1, nr_reg=9; reset pulse mid-stream -> outputs 0 immediately.

Source files
------------

// File: rtl/dispatch_rr_multi_if.sv
// Dispatch stage port bundle: rename input, PRF busy/query, CDB wakeup,
// ROB allocation and per-RS write. The dispatch stage is the slave.
interface dispatch_rr_multi_if #(
    parameter int N_CH      = 3,
    parameter int PREG_W    = 7,
    parameter int PAYLOAD_W = 96,
    parameter int N_CDB     = 3
);
    localparam int CH_W = $clog2(N_CH);

    logic                      flush;
    logic                      in_valid;
    logic                      in_ready;
    logic [CH_W-1:0]           in_ch;
    logic [PREG_W-1:0]         in_ps1;
    logic [PREG_W-1:0]         in_ps2;
    logic [PREG_W-1:0]         in_pd;
    logic [PAYLOAD_W-1:0]      in_payload;
    logic                      nr_valid;
    logic [PREG_W-1:0]         nr_reg;
    logic [PREG_W-1:0]         query_ps1;
    logic [PREG_W-1:0]         query_ps2;
    logic                      query_rdy1;
    logic                      query_rdy2;
    logic [N_CDB-1:0]          cdb_valid;
    logic [N_CDB*PREG_W-1:0]   cdb_tag;
    logic                      rob_full;
    logic                      rob_we;
    logic [N_CH-1:0]           rs_space;
    logic [N_CH-1:0]           rs_we;
    logic [PREG_W-1:0]         out_ps1;
    logic [PREG_W-1:0]         out_ps2;
    logic [PREG_W-1:0]         out_pd;
    logic [PAYLOAD_W-1:0]      out_payload;
    logic                      out_pr1_ready;
    logic                      out_pr2_ready;

    modport master (
        output flush, in_valid, in_ch, in_ps1, in_ps2, in_pd, in_payload,
               query_rdy1, query_rdy2, cdb_valid, cdb_tag, rob_full, rs_space,
        input  in_ready, nr_valid, nr_reg, query_ps1, query_ps2, rob_we, rs_we,
               out_ps1, out_ps2, out_pd, out_payload, out_pr1_ready, out_pr2_ready
    );

    modport slave (
        input  flush, in_valid, in_ch, in_ps1, in_ps2, in_pd, in_payload,
               query_rdy1, query_rdy2, cdb_valid, cdb_tag, rob_full, rs_space,
        output in_ready, nr_valid, nr_reg, query_ps1, query_ps2, rob_we, rs_we,
               out_ps1, out_ps2, out_pd, out_payload, out_pr1_ready, out_pr2_ready
    );
endinterface

// File: rtl/dispatch_rr_multi.sv
// Dispatch stage: steers renamed packets into per-channel FIFOs and grants one
// head per cycle round-robin to its RS and the ROB, resolving source readiness.
module dispatch_rr_multi #(
    parameter int N_CH      = 3,
    parameter int DEPTH     = 2,
    parameter int PREG_W    = 7,
    parameter int PAYLOAD_W = 96,
    parameter int N_CDB     = 3
) (
    input logic               clk,
    input logic               reset,
    dispatch_rr_multi_if.slave bus
);
    localparam int CH_W  = $clog2(N_CH);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    function automatic logic cdb_hit(input logic [PREG_W-1:0]       tag,
                                     input logic [N_CDB-1:0]        vld,
                                     input logic [N_CDB*PREG_W-1:0] tags);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < N_CDB; k++) begin
            if (vld[k] && (tags[k*PREG_W +: PREG_W] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    function automatic logic [CH_W-1:0] ch_add(input logic [CH_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N_CH) s = s - N_CH;
        return CH_W'(s);
    endfunction

    // Stage p0: per-channel FIFO storage (data, no reset) and its control state
    logic [PREG_W-1:0]    ps1_p0  [N_CH][DEPTH];
    logic [PREG_W-1:0]    ps2_p0  [N_CH][DEPTH];
    logic [PREG_W-1:0]    pd_p0   [N_CH][DEPTH];
    logic [PAYLOAD_W-1:0] pl_p0   [N_CH][DEPTH];
    logic                 rdy1_p0 [N_CH][DEPTH];
    logic                 rdy2_p0 [N_CH][DEPTH];
    logic [PTR_W-1:0]     wr_ptr  [N_CH];
    logic [PTR_W-1:0]     rd_ptr  [N_CH];
    logic [CNT_W-1:0]     count   [N_CH];
    logic [CH_W-1:0]      rr_ptr;

    logic                 in_ch_ok;
    logic                 sel_full;
    logic                 enq;
    logic [N_CH-1:0]      enq_vec;
    logic [N_CH-1:0]      deq_vec;
    logic [N_CH-1:0]      elig;
    logic                 gnt_vld;
    logic [CH_W-1:0]      gnt_ch;
    logic [PREG_W-1:0]    h_ps1, h_ps2, h_pd;
    logic [PAYLOAD_W-1:0] h_pl;
    logic                 h_rdy1, h_rdy2;

    // Acceptance looks only at registered occupancy, so a dequeue gives no credit.
    always_comb begin
        in_ch_ok = (int'(bus.in_ch) < N_CH);
        sel_full = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            if ((bus.in_ch == CH_W'(c)) && (count[c] == CNT_W'(DEPTH))) sel_full = 1'b1;
        end
        bus.in_ready = !reset && !bus.flush && !sel_full;
        enq          = bus.in_valid && bus.in_ready && in_ch_ok;
        bus.nr_valid = enq && (bus.in_pd != '0);
        bus.nr_reg   = bus.in_pd;
        for (int c = 0; c < N_CH; c++) begin
            enq_vec[c] = enq && (bus.in_ch == CH_W'(c));
            elig[c]    = (count[c] != '0) && bus.rs_space[c] && !bus.rob_full
                         && !bus.flush && !reset;
        end
    end

    // Descending scan so the closest eligible channel at/after rr_ptr wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_ch  = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (elig[ch_add(rr_ptr, i)]) begin
                gnt_vld = 1'b1;
                gnt_ch  = ch_add(rr_ptr, i);
            end
        end
        h_ps1  = '0;
        h_ps2  = '0;
        h_pd   = '0;
        h_pl   = '0;
        h_rdy1 = 1'b0;
        h_rdy2 = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            deq_vec[c] = gnt_vld && (gnt_ch == CH_W'(c));
            if (deq_vec[c]) begin
                h_ps1  = ps1_p0[c][rd_ptr[c]];
                h_ps2  = ps2_p0[c][rd_ptr[c]];
                h_pd   = pd_p0[c][rd_ptr[c]];
                h_pl   = pl_p0[c][rd_ptr[c]];
                h_rdy1 = rdy1_p0[c][rd_ptr[c]];
                h_rdy2 = rdy2_p0[c][rd_ptr[c]];
            end
        end
    end

    // Stage p1 boundary: granted head presented to RS, ROB and PRF query
    always_comb begin
        bus.rs_we         = deq_vec;
        bus.rob_we        = gnt_vld;
        bus.query_ps1     = gnt_vld ? h_ps1 : '0;
        bus.query_ps2     = gnt_vld ? h_ps2 : '0;
        bus.out_ps1       = gnt_vld ? h_ps1 : '0;
        bus.out_ps2       = gnt_vld ? h_ps2 : '0;
        bus.out_pd        = gnt_vld ? h_pd  : '0;
        bus.out_payload   = gnt_vld ? h_pl  : '0;
        bus.out_pr1_ready = gnt_vld && ((h_ps1 == '0) || h_rdy1 || bus.query_rdy1
                                        || cdb_hit(h_ps1, bus.cdb_valid, bus.cdb_tag));
        bus.out_pr2_ready = gnt_vld && ((h_ps2 == '0) || h_rdy2 || bus.query_rdy2
                                        || cdb_hit(h_ps2, bus.cdb_valid, bus.cdb_tag));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < N_CH; c++) begin
                count[c]  <= '0;
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
            rr_ptr <= '0;
        end else if (bus.flush) begin
            for (int c = 0; c < N_CH; c++) begin
                count[c]  <= '0;
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
            end
        end else begin
            for (int c = 0; c < N_CH; c++) begin
                if (enq_vec[c]) wr_ptr[c] <= wr_ptr[c] + PTR_W'(1);
                if (deq_vec[c]) rd_ptr[c] <= rd_ptr[c] + PTR_W'(1);
                count[c] <= count[c] + CNT_W'(enq_vec[c]) - CNT_W'(deq_vec[c]);
            end
            if (gnt_vld) rr_ptr <= ch_add(gnt_ch, 1);
        end
    end

    // Buffered entries keep snooping the CDB so a wakeup seen in the FIFO is not lost.
    always_ff @(posedge clk) begin
        for (int c = 0; c < N_CH; c++) begin
            for (int e = 0; e < DEPTH; e++) begin
                rdy1_p0[c][e] <= rdy1_p0[c][e] | cdb_hit(ps1_p0[c][e], bus.cdb_valid, bus.cdb_tag);
                rdy2_p0[c][e] <= rdy2_p0[c][e] | cdb_hit(ps2_p0[c][e], bus.cdb_valid, bus.cdb_tag);
            end
            if (enq_vec[c]) begin
                ps1_p0[c][wr_ptr[c]]  <= bus.in_ps1;
                ps2_p0[c][wr_ptr[c]]  <= bus.in_ps2;
                pd_p0[c][wr_ptr[c]]   <= bus.in_pd;
                pl_p0[c][wr_ptr[c]]   <= bus.in_payload;
                rdy1_p0[c][wr_ptr[c]] <= (bus.in_ps1 == '0)
                                         || cdb_hit(bus.in_ps1, bus.cdb_valid, bus.cdb_tag);
                rdy2_p0[c][wr_ptr[c]] <= (bus.in_ps2 == '0)
                                         || cdb_hit(bus.in_ps2, bus.cdb_valid, bus.cdb_tag);
            end
        end
    end
endmodule

// File: tb/tb_dispatch_rr_multi.sv
// Directed bench for dispatch_rr_multi: grant order, backpressure, readiness
// resolution, flush and reset behaviour against hand-computed expectations.
module tb_dispatch_rr_multi;
    localparam int N_CH      = 3;
    localparam int DEPTH     = 2;
    localparam int PREG_W    = 7;
    localparam int PAYLOAD_W = 96;
    localparam int N_CDB     = 3;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    dispatch_rr_multi_if #(.N_CH(N_CH), .PREG_W(PREG_W), .PAYLOAD_W(PAYLOAD_W), .N_CDB(N_CDB)) bus();

    dispatch_rr_multi #(.N_CH(N_CH), .DEPTH(DEPTH), .PREG_W(PREG_W),
                        .PAYLOAD_W(PAYLOAD_W), .N_CDB(N_CDB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    function automatic logic [95:0] pl(input logic [6:0] pd);
        return {24'hC0FFEE, 65'd0, pd};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [2:0] we, input logic [6:0] pd);
        check({tag, "_rs_we"},   128'(bus.rs_we),       128'(we));
        check({tag, "_rob_we"},  128'(bus.rob_we),      128'(|we));
        check({tag, "_out_pd"},  128'(bus.out_pd),      128'(pd));
        check({tag, "_payload"}, 128'(bus.out_payload), (we != 3'b000) ? 128'(pl(pd)) : 128'(0));
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] ch, input logic [6:0] p1, input logic [6:0] p2,
                         input logic [6:0] pd);
        bus.in_valid   = 1'b1;
        bus.in_ch      = ch;
        bus.in_ps1     = p1;
        bus.in_ps2     = p2;
        bus.in_pd      = pd;
        bus.in_payload = pl(pd);
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset          = 1'b1;
        bus.flush      = 1'b0;
        bus.query_rdy1 = 1'b0;
        bus.query_rdy2 = 1'b0;
        bus.cdb_valid  = '0;
        bus.cdb_tag    = '0;
        bus.rob_full   = 1'b0;
        bus.rs_space   = 3'b111;
        drive(2'd0, 7'd0, 7'd0, 7'd9);
        #2;
        check("rst_in_ready", 128'(bus.in_ready), 128'(0));
        check("rst_nr_valid", 128'(bus.nr_valid), 128'(0));
        check("rst_rs_we",    128'(bus.rs_we),    128'(0));
        check("rst_rob_we",   128'(bus.rob_we),   128'(0));
        cyc();
        cyc();
        reset = 1'b0;
        idle();
        #1;

        // 1: one packet per channel, granted in order one cycle after accept
        drive(2'd0, 7'd1, 7'd0, 7'd10);
        #1;
        check("t1_in_ready", 128'(bus.in_ready), 128'(1));
        check("t1_nr_valid", 128'(bus.nr_valid), 128'(1));
        check("t1_nr_reg",   128'(bus.nr_reg),   128'(10));
        chk_grant("t1_c1", 3'b000, 7'd0);
        cyc();
        drive(2'd1, 7'd2, 7'd3, 7'd11);
        #1;
        chk_grant("t1_c2", 3'b001, 7'd10);
        cyc();
        drive(2'd2, 7'd4, 7'd0, 7'd12);
        #1;
        chk_grant("t1_c3", 3'b010, 7'd11);
        cyc();
        idle();
        #1;
        chk_grant("t1_c4", 3'b100, 7'd12);
        cyc();
        chk_grant("t1_c5", 3'b000, 7'd0);

        // 2: ch1 full while its RS is blocked; other channel still accepts
        bus.rs_space = 3'b101;
        drive(2'd1, 7'd0, 7'd0, 7'd21);
        #1;
        check("t2_acc1", 128'(bus.in_ready), 128'(1));
        cyc();
        drive(2'd1, 7'd0, 7'd0, 7'd22);
        #1;
        check("t2_acc2", 128'(bus.in_ready), 128'(1));
        cyc();
        drive(2'd1, 7'd0, 7'd0, 7'd23);
        #1;
        check("t2_full_ready", 128'(bus.in_ready), 128'(0));
        check("t2_full_nr",    128'(bus.nr_valid), 128'(0));
        check("t2_blk_rs_we",  128'(bus.rs_we),    128'(0));
        bus.in_ch = 2'd0;
        #1;
        check("t2_ch0_ready", 128'(bus.in_ready), 128'(1));
        idle();
        bus.in_ch = 2'd1;
        bus.rs_space = 3'b111;
        #1;
        chk_grant("t2_g0", 3'b010, 7'd21);
        check("t2_no_credit", 128'(bus.in_ready), 128'(0));
        cyc();
        chk_grant("t2_g1", 3'b010, 7'd22);
        check("t2_ready_back", 128'(bus.in_ready), 128'(1));
        cyc();
        chk_grant("t2_empty", 3'b000, 7'd0);

        // 3: readiness from CDB in the grant cycle and while buffered
        bus.rs_space = 3'b110;
        drive(2'd0, 7'd5, 7'd0, 7'd30);
        cyc();
        drive(2'd0, 7'd6, 7'd8, 7'd31);
        cyc();
        idle();
        bus.rs_space  = 3'b111;
        bus.cdb_valid = 3'b110;
        bus.cdb_tag   = {7'd6, 7'd5, 7'd5};
        #1;
        chk_grant("t3_g0", 3'b001, 7'd30);
        check("t3_query_ps1", 128'(bus.query_ps1),     128'(5));
        check("t3_out_ps1",   128'(bus.out_ps1),       128'(5));
        check("t3_pr1_cdb",   128'(bus.out_pr1_ready), 128'(1));
        check("t3_pr2_zero",  128'(bus.out_pr2_ready), 128'(1));
        cyc();
        bus.cdb_valid = 3'b000;
        bus.cdb_tag   = {7'd0, 7'd0, 7'd8};
        #1;
        chk_grant("t3_g1", 3'b001, 7'd31);
        check("t3_query_ps2",  128'(bus.query_ps2),     128'(8));
        check("t3_pr1_stored", 128'(bus.out_pr1_ready), 128'(1));
        check("t3_pr2_busy",   128'(bus.out_pr2_ready), 128'(0));
        bus.query_rdy2 = 1'b1;
        #1;
        check("t3_pr2_prf", 128'(bus.out_pr2_ready), 128'(1));
        cyc();
        bus.query_rdy2 = 1'b0;

        // 4: round-robin from rr_ptr=2 with a two-cycle ROB stall
        bus.rs_space = 3'b000;
        drive(2'd1, 7'd0, 7'd0, 7'd40); cyc();
        drive(2'd2, 7'd0, 7'd0, 7'd50); cyc();
        drive(2'd0, 7'd0, 7'd0, 7'd60); cyc();
        drive(2'd1, 7'd0, 7'd0, 7'd41); cyc();
        drive(2'd2, 7'd0, 7'd0, 7'd51); cyc();
        drive(2'd0, 7'd0, 7'd0, 7'd61); cyc();
        idle();
        bus.rs_space = 3'b010;
        #1;
        chk_grant("t4_set_rr", 3'b010, 7'd40);
        cyc();
        bus.rs_space = 3'b111;
        #1;
        chk_grant("t4_g2", 3'b100, 7'd50);
        cyc();
        chk_grant("t4_g0", 3'b001, 7'd60);
        cyc();
        bus.rob_full = 1'b1;
        #1;
        chk_grant("t4_stall0", 3'b000, 7'd0);
        cyc();
        chk_grant("t4_stall1", 3'b000, 7'd0);
        cyc();
        bus.rob_full = 1'b0;
        #1;
        chk_grant("t4_g1", 3'b010, 7'd41);
        cyc();
        chk_grant("t4_g2b", 3'b100, 7'd51);
        cyc();
        chk_grant("t4_g0b", 3'b001, 7'd61);
        cyc();
        chk_grant("t4_empty", 3'b000, 7'd0);

        // 5: flush with four packets buffered; rr_ptr (=1) survives
        bus.rs_space = 3'b000;
        drive(2'd0, 7'd0, 7'd0, 7'd70); cyc();
        drive(2'd0, 7'd0, 7'd0, 7'd71); cyc();
        drive(2'd1, 7'd0, 7'd0, 7'd72); cyc();
        drive(2'd2, 7'd0, 7'd0, 7'd73); cyc();
        bus.flush    = 1'b1;
        bus.rs_space = 3'b111;
        drive(2'd2, 7'd0, 7'd0, 7'd74);
        #1;
        check("t5_fl_ready",  128'(bus.in_ready), 128'(0));
        check("t5_fl_nr",     128'(bus.nr_valid), 128'(0));
        check("t5_fl_rs_we",  128'(bus.rs_we),    128'(0));
        check("t5_fl_rob_we", 128'(bus.rob_we),   128'(0));
        cyc();
        bus.flush = 1'b0;
        idle();
        bus.in_ch = 2'd0;
        #1;
        chk_grant("t5_after", 3'b000, 7'd0);
        check("t5_ready_ch0", 128'(bus.in_ready), 128'(1));
        bus.rs_space = 3'b000;
        drive(2'd0, 7'd0, 7'd0, 7'd75); cyc();
        drive(2'd1, 7'd0, 7'd0, 7'd76); cyc();
        idle();
        bus.rs_space = 3'b111;
        #1;
        chk_grant("t5_rr_kept", 3'b010, 7'd76);
        cyc();
        chk_grant("t5_rr_next", 3'b001, 7'd75);
        cyc();

        // 6: nr_valid rules, out-of-range channel drop, mid-cycle reset
        bus.rs_space = 3'b000;
        drive(2'd2, 7'd0, 7'd0, 7'd0);
        #1;
        check("t6_pd0_ready", 128'(bus.in_ready), 128'(1));
        check("t6_pd0_nr",    128'(bus.nr_valid), 128'(0));
        cyc();
        drive(2'd2, 7'd0, 7'd0, 7'd9);
        #1;
        check("t6_pd9_nr",  128'(bus.nr_valid), 128'(1));
        check("t6_pd9_reg", 128'(bus.nr_reg),   128'(9));
        cyc();
        drive(2'd3, 7'd0, 7'd0, 7'd5);
        #1;
        check("t6_bad_ready", 128'(bus.in_ready), 128'(1));
        check("t6_bad_nr",    128'(bus.nr_valid), 128'(0));
        cyc();
        idle();
        bus.rs_space = 3'b111;
        #1;
        chk_grant("t6_g_pd0", 3'b100, 7'd0);
        cyc();
        drive(2'd0, 7'd0, 7'd0, 7'd9);
        #1;
        chk_grant("t6_g_pd9", 3'b100, 7'd9);
        check("t6_pre_nr", 128'(bus.nr_valid), 128'(1));
        reset = 1'b1;
        #1;
        check("t6_rst_rs_we",  128'(bus.rs_we),    128'(0));
        check("t6_rst_rob_we", 128'(bus.rob_we),   128'(0));
        check("t6_rst_nr",     128'(bus.nr_valid), 128'(0));
        check("t6_rst_ready",  128'(bus.in_ready), 128'(0));
        check("t6_rst_out_pd", 128'(bus.out_pd),   128'(0));
        #2;
        reset = 1'b0;
        idle();
        cyc();
        chk_grant("t6_post_rst", 3'b000, 7'd0);
        check("t6_post_ready", 128'(bus.in_ready), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
